// File: rtl/multicycle_controller.sv
// Multicycle control FSM for a small RISC-V style datapath: FETCH/DECODE/EXECUTE/MEM/WB with
// a bounded data-memory wait, a retired-instruction counter, and an absorbing HALT on faults.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        ir_write_en,
  output logic        pc_write_en,
  output logic [1:0]  pc_src,
  output logic        reg_write_en,
  output logic [1:0]  wb_sel,
  output logic        alu_src,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [2:0]  state,
  output logic        halted,
  output logic [1:0]  fault,
  output logic [31:0] retired
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [1:0] FaultNone    = 2'd0;
  localparam logic [1:0] FaultIllegal = 2'd1;
  localparam logic [1:0] FaultTimeout = 2'd2;

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StDecode  = 3'd1,
    StExecute = 3'd2,
    StMem     = 3'd3,
    StWb      = 3'd4,
    StHalt    = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [6:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [1:0]        fault_q, fault_d;
  logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [31:0]       retired_q, retired_d;
  logic              legal_op;
  logic              is_load;

  always_comb begin
    legal_op = (opcode == OpR) || (opcode == OpIAlu) || (opcode == OpLoad) ||
               (opcode == OpStore) || (opcode == OpBranch) || (opcode == OpJal);
    is_load  = (op_q == OpLoad);
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rd_d         = rd_q;
    fault_d      = fault_q;
    wait_cnt_d   = wait_cnt_q;
    ir_write_en  = 1'b0;
    pc_write_en  = 1'b0;
    pc_src       = 2'd0;
    reg_write_en = 1'b0;
    wb_sel       = 2'd0;
    alu_src      = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;

    // Outputs are combinational from state, so they are gated to keep everything quiet in reset.
    if (!reset) begin
      case (state_q)
        StFetch: begin
          ir_write_en = 1'b1;
          state_d     = StDecode;
        end
        StDecode: begin
          op_d = opcode;
          rd_d = rd;
          if (legal_op) begin
            state_d = StExecute;
          end else begin
            state_d = StHalt;
            fault_d = FaultIllegal;
          end
        end
        StExecute: begin
          case (op_q)
            OpR: state_d = StWb;
            OpIAlu: begin
              alu_src = 1'b1;
              state_d = StWb;
            end
            OpLoad, OpStore: begin
              alu_src    = 1'b1;
              wait_cnt_d = '0;
              state_d    = StMem;
            end
            OpBranch: begin
              pc_write_en = 1'b1;
              pc_src      = zero ? 2'd1 : 2'd0;
              state_d     = StFetch;
            end
            OpJal: begin
              pc_write_en  = 1'b1;
              pc_src       = 2'd2;
              reg_write_en = (rd_q != 5'd0);
              wb_sel       = 2'd2;
              state_d      = StFetch;
            end
            default: begin
              state_d = StHalt;
              fault_d = FaultIllegal;
            end
          endcase
        end
        StMem: begin
          mem_read_en  = is_load;
          mem_write_en = !is_load;
          if (mem_ready) begin
            if (is_load) begin
              state_d = StWb;
            end else begin
              pc_write_en = 1'b1;
              state_d     = StFetch;
            end
          end else begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
            if (wait_cnt_d == CntW'(MEM_TIMEOUT)) begin
              state_d = StHalt;
              fault_d = FaultTimeout;
            end
          end
        end
        StWb: begin
          reg_write_en = (rd_q != 5'd0);
          wb_sel       = is_load ? 2'd1 : 2'd0;
          pc_write_en  = 1'b1;
          state_d      = StFetch;
        end
        StHalt: ;
        default: begin
          state_d = StHalt;
          fault_d = FaultIllegal;
        end
      endcase
    end

    retired_d = retired_q + {31'd0, pc_write_en};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StFetch;
      op_q       <= 7'd0;
      rd_q       <= 5'd0;
      fault_q    <= FaultNone;
      wait_cnt_q <= '0;
      retired_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      fault_q    <= fault_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
    end
  end

  assign state   = state_q;
  assign halted  = (state_q == StHalt);
  assign fault   = fault_q;
  assign retired = retired_q;

endmodule
